// File: rtl/knn_seq_stream.sv
// -----------------------------------------------------------------------------
// knn_seq_stream
// Streaming k-nearest-neighbour selector. Each job arrives on a valid/ready
// input stream: the first beat is the query and the next N beats are the
// points. The distance of every point is |point - query|, unsigned. The block
// keeps a K-entry list sorted by ascending distance and updates it in the same
// cycle each point is accepted, so the input never stalls while points arrive.
// When the job is complete, the K nearest points are streamed out, nearest
// first. On equal distance the point that arrived earlier ranks ahead.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input beat offered
//   in_ready   : input beat accepted when in_valid & in_ready
//   in_data    : query (first beat of a job) or point (next N beats)
//   out_valid  : out_data holds a result beat
//   out_ready  : consumer takes a result beat when out_valid & out_ready
//   out_data   : point value of the current result
//   out_last   : marks the K-th (final) result beat of a job
//   busy       : high whenever the block is not idle
// -----------------------------------------------------------------------------
module knn_seq_stream #(
  parameter int W = 32,
  parameter int K = 2,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  // Point counter must reach N; output index must reach K-1.
  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_query;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_slot_data [K];
  logic [W-1:0]   r_slot_dist [K];
  logic [K-1:0]   r_slot_vld;

  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_out_last;
  logic           r_busy;

  logic [W-1:0]   w_dist;
  logic [K-1:0]   w_qual;
  logic [W-1:0]   w_new_data [K];
  logic [W-1:0]   w_new_dist [K];
  logic [K-1:0]   w_new_vld;
  logic           w_in_fire;
  logic           w_out_fire;
  logic [IW-1:0]  w_idx_nxt;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_idx_nxt  = r_idx + IW'(1);

  // Absolute difference without overflow: subtract the smaller from the larger.
  assign w_dist = (in_data >= r_query) ? (in_data - r_query) : (r_query - in_data);

  // A slot qualifies when it is empty or strictly farther than the new point.
  // Strict comparison keeps an earlier point ahead on a tie. Because the list
  // is sorted and empty slots sit at the tail, w_qual is monotonic: once a
  // slot qualifies, every slot after it qualifies too. So the insertion point
  // is the first qualifying slot, and every later slot takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      assign w_qual[gi] = ~r_slot_vld[gi] | (r_slot_dist[gi] > w_dist);

      if (gi == 0) begin : g_head
        assign w_new_data[gi] = w_qual[gi] ? in_data : r_slot_data[gi];
        assign w_new_dist[gi] = w_qual[gi] ? w_dist  : r_slot_dist[gi];
        assign w_new_vld[gi]  = w_qual[gi] | r_slot_vld[gi];
      end else begin : g_tail
        assign w_new_data[gi] = w_qual[gi-1] ? r_slot_data[gi-1] :
                                w_qual[gi]   ? in_data           : r_slot_data[gi];
        assign w_new_dist[gi] = w_qual[gi-1] ? r_slot_dist[gi-1] :
                                w_qual[gi]   ? w_dist            : r_slot_dist[gi];
        assign w_new_vld[gi]  = w_qual[gi-1] ? r_slot_vld[gi-1]  :
                                (w_qual[gi] | r_slot_vld[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_query     <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_slot_vld  <= '0;
      for (int i = 0; i < K; i++) begin
        r_slot_data[i] <= '0;
        r_slot_dist[i] <= '0;
      end
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_query    <= in_data;
            r_cnt      <= '0;
            r_slot_vld <= '0;
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_in_fire) begin
            for (int i = 0; i < K; i++) begin
              r_slot_data[i] <= w_new_data[i];
              r_slot_dist[i] <= w_new_dist[i];
            end
            r_slot_vld <= w_new_vld;
            r_cnt      <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
              // Head of the updated list is presented the very next cycle.
              r_state     <= S_DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_new_data[0];
              r_out_last  <= (K == 1);
              r_idx       <= '0;
            end
          end
        end

        S_DRAIN: begin
          if (w_out_fire) begin
            if (r_idx == IW'(K - 1)) begin
              r_state     <= S_IDLE;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_data <= r_slot_data[w_idx_nxt];
              r_out_last <= (w_idx_nxt == IW'(K - 1));
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_seq_stream.sv
module tb_knn_seq_stream;

  logic        clk;
  logic        rst_n;

  // Shared drive, steered to one instance by sel (0: K=2 unit, 1: K=4 unit).
  logic        sel;
  logic        iv;
  logic [31:0] idata;
  logic        ordy;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [31:0] a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [31:0] b_out_data;

  logic        c_in_ready, c_out_valid, c_out_last, c_busy;
  logic [31:0] c_out_data;

  int n_chk;
  int n_pass;

  assign a_in_valid  = iv & ~sel;
  assign a_out_ready = ordy & ~sel;
  assign b_in_valid  = iv & sel;
  assign b_out_ready = ordy & sel;

  assign c_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign c_out_valid = sel ? b_out_valid : a_out_valid;
  assign c_out_last  = sel ? b_out_last  : a_out_last;
  assign c_out_data  = sel ? b_out_data  : a_out_data;
  assign c_busy      = sel ? b_busy      : a_busy;

  knn_seq_stream #(.W(32), .K(2), .N(4)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (idata),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_data (a_out_data),
    .out_last (a_out_last),
    .busy     (a_busy)
  );

  knn_seq_stream #(.W(32), .K(4), .N(4)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (idata),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_data (b_out_data),
    .out_last (b_out_last),
    .busy     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s obs=%08h exp=%08h", tag, obs, exp);
    end else begin
      $display("FAIL %-14s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int t;
    t = 0;
    iv    = 1'b1;
    idata = d;
    while (!c_in_ready && t < 20) begin
      cyc();
      t++;
    end
    if (t >= 20) chk_val("send_tmo", {31'b0, c_in_ready}, 32'd1);
    cyc();
    iv = 1'b0;
  endtask

  task automatic send_job(input logic [31:0] q, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3);
    send(q);
    send(p0);
    send(p1);
    send(p2);
    send(p3);
    // Result must be visible in the cycle right after the last point.
    chk_val("latency", {31'b0, c_out_valid}, 32'd1);
  endtask

  task automatic recv(input string tag, input logic [31:0] exp_d, input logic exp_l);
    int t;
    t = 0;
    while (!c_out_valid && t < 20) begin
      cyc();
      t++;
    end
    chk_val(tag, c_out_data, exp_d);
    chk_val({tag, "_last"}, {31'b0, c_out_last}, {31'b0, exp_l});
    ordy = 1'b1;
    cyc();
    ordy = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    sel   = 1'b0;
    iv    = 1'b0;
    idata = '0;
    ordy  = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk_val("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk_val("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk_val("rst_out_last", {31'b0, a_out_last}, 32'd0);
    chk_val("rst_busy", {31'b0, a_busy}, 32'd0);
    chk_val("rst_out_data", a_out_data, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic job with a tie: 7 loses to 13
    send_job(32'd10, 32'd13, 32'd7, 32'd20, 32'd9);
    chk_val("drain_busy", {31'b0, a_busy}, 32'd1);
    chk_val("drain_in_rdy", {31'b0, a_in_ready}, 32'd0);
    recv("j1_r0", 32'd9, 1'b0);
    recv("j1_r1", 32'd13, 1'b1);
    chk_val("j1_idle_rdy", {31'b0, a_in_ready}, 32'd1);
    chk_val("j1_idle_busy", {31'b0, a_busy}, 32'd0);

    // Back-pressure: output held for 5 cycles
    send_job(32'd10, 32'd13, 32'd7, 32'd20, 32'd9);
    for (int i = 0; i < 5; i++) begin
      chk_val("bp_valid", {31'b0, a_out_valid}, 32'd1);
      chk_val("bp_data", a_out_data, 32'd9);
      chk_val("bp_last", {31'b0, a_out_last}, 32'd0);
      cyc();
    end
    recv("bp_r0", 32'd9, 1'b0);
    recv("bp_r1", 32'd13, 1'b1);
    chk_val("bp_once", {31'b0, a_out_valid}, 32'd0);

    // Boundary values
    send_job(32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF);
    recv("bd0_r0", 32'd0, 1'b0);
    recv("bd0_r1", 32'd1, 1'b1);
    send_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF);
    recv("bd1_r0", 32'hFFFF_FFFF, 1'b0);
    recv("bd1_r1", 32'hFFFF_FFFF, 1'b1);

    // Reset in the middle of LOAD
    send(32'd50);
    send(32'd51);
    send(32'd52);
    chk_val("mid_busy", {31'b0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("async_rdy", {31'b0, a_in_ready}, 32'd1);
    chk_val("async_busy", {31'b0, a_busy}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    send_job(32'd100, 32'd90, 32'd101, 32'd150, 32'd99);
    recv("ab_r0", 32'd101, 1'b0);
    recv("ab_r1", 32'd99, 1'b1);

    // K = N = 4
    sel = 1'b1;
    cyc();
    send_job(32'd5, 32'd8, 32'd2, 32'd5, 32'd6);
    recv("k4_r0", 32'd5, 1'b0);
    recv("k4_r1", 32'd6, 1'b0);
    recv("k4_r2", 32'd8, 1'b0);
    recv("k4_r3", 32'd2, 1'b1);
    chk_val("k4_idle", {31'b0, b_busy}, 32'd0);
    sel = 1'b0;
    cyc();

    // in_valid held through DRAIN, next query back-to-back
    send_job(32'd10, 32'd13, 32'd7, 32'd20, 32'd9);
    iv    = 1'b1;
    idata = 32'd100;
    chk_val("b2b_rdy0", {31'b0, a_in_ready}, 32'd0);
    recv("b2b_r0", 32'd9, 1'b0);
    chk_val("b2b_rdy1", {31'b0, a_in_ready}, 32'd0);
    recv("b2b_r1", 32'd13, 1'b1);
    chk_val("b2b_rdy2", {31'b0, a_in_ready}, 32'd1);
    chk_val("b2b_busy0", {31'b0, a_busy}, 32'd0);
    cyc();
    iv = 1'b0;
    chk_val("b2b_busy1", {31'b0, a_busy}, 32'd1);
    send(32'd90);
    send(32'd101);
    send(32'd150);
    send(32'd99);
    chk_val("b2b_lat", {31'b0, a_out_valid}, 32'd1);
    recv("b2b_n0", 32'd101, 1'b0);
    recv("b2b_n1", 32'd99, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
